mem_access_unit: RTL
====================

# mem_access_unit

Load/store sequencer between the EX/MEM pipeline register and `data_memory`. It converts byte, halfword and word loads and stores into word-wide accesses on the data-memory port. Sub-word stores use a read-modify-write sequence. It drives registered, glitch-free memory controls and returns aligned, extended load data to the MEM/WB path.

## Interface
- `ADDR_W`, 32, request/memory address width
- `DATA_W`, 32, data width; fixed at 32 for lane logic
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present; sampled only in IDLE
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
- `req_signed`  in  1  loads: 1 sign-extend, 0 zero-extend
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data, right-justified
- `stall`  out  1  unit busy; upstream holds pipeline
- `resp_valid`  out  1  one-cycle completion pulse (loads and stores)
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores
- `misalign`  out  1  qualifies `resp_valid`: request rejected as misaligned
- `mem_addr`  out  ADDR_W  word-aligned address `{addr[ADDR_W-1:2],2'b00}`, registered
- `mem_wdata`  out  DATA_W  registered write word
- `mem_read`  out  1  registered read enable
- `mem_write`  out  1  registered write strobe; memory commits on its rising edge
- `mem_rdata`  in  DATA_W  combinational read data from memory

## Operation
- States: IDLE, RD, WSETUP, WR.
- IDLE with `req_valid`: capture request.
  - Load → RD.
  - Word store → WSETUP, with `mem_wdata`=`req_wdata`.
  - Sub-word store → RD.
- RD: `mem_read`=1.
  - Load: at cycle end, select lane `addr[1:0]` (little-endian; byte 0 = bits 7:0), extend, register into `resp_rdata`, pulse `resp_valid`, → IDLE.
  - Sub-word store: merge `req_wdata` low byte/half into `mem_rdata` at lane → `mem_wdata`, → WSETUP.
- WSETUP: address/data stable, no strobe; → WR.
- WR: `mem_write`=1 for exactly one cycle; → IDLE with `resp_valid` pulse.
- `stall`=1 in every non-IDLE state; 0 in IDLE. Upstream must not change request fields while `stall`=1.
- `mem_addr`/`mem_wdata` change only on acceptance or leaving RD. They are never changed in the cycle `mem_write` rises or the cycle after it falls.
- `mem_read` and `mem_write` are never both high.
- Reset (async, any state): state IDLE; `stall`, `resp_valid`, `misalign`, `mem_read`, `mem_write` = 0; `resp_rdata`, `mem_addr`, `mem_wdata` = 0. An in-flight RMW is abandoned. A write whose strobe already rose is committed.

## Timing
- Request accepted in cycle T (IDLE).
- Load: RD at T+1; `resp_valid` at T+2.
- Word store: WSETUP T+1, WR T+2; `resp_valid` T+3.
- Sub-word store: RD T+1, WSETUP T+2, WR T+3; `resp_valid` T+4.
- Next request can be accepted in the same cycle `resp_valid` is high (state is IDLE).
- Misaligned request: no memory activity. `resp_valid`=`misalign`=1 at T+1 and `resp_rdata`=0.

## Configuration
- `MEM_ACCESS_ALIGN_CHECK_EN` defined:
  - Halfword with `addr[0]`=1 is rejected as misaligned.
  - Word with `addr[1:0]`≠0 is rejected as misaligned.
- Undefined:
  - `misalign` is tied 0.
  - Halfword lane uses `addr[1]` only; word ignores `addr[1:0]`.
  - No request is rejected.

## Structure
- Package `mem_access_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), state enum, lane-select constants.
- Sub-module `mem_load_align`: combinational lane extract plus sign/zero extension, reused by the RMW merge path for lane masks.
- Top: FSM and registered memory-port outputs.

## Test plan
- Memory word 0x0 = 0x8899AABB; `lb` addr 0x2, signed → `resp_rdata`=0xFFFFFF99 at T+2; unsigned → 0x00000099.
- `lh` addr 0x2, signed, same word → 0xFFFF8899; `lw` 0x0 → 0x8899AABB; `mem_write` never high.
- `sb` 0x11 to addr 0x1 on word 0x8899AABB → one `mem_write` pulse at T+3, word becomes 0x889911BB, `resp_valid` at T+4. Check `mem_addr`/`mem_wdata` are stable from T+2 through T+4.
- `sw` 0xDEADBEEF to 0x10 → `mem_write` high only at T+2, `resp_valid` T+3, `stall` high T+1–T+2; a following load accepted at T+3 reads back 0xDEADBEEF.
- With `MEM_ACCESS_ALIGN_CHECK_EN`: `lw` addr 0x6 → `misalign`=1, `resp_valid` at T+1, no `mem_read`/`mem_write`. Without the macro: same request reads word 0x4.
- `rst_n` low during WSETUP of a `sb` → all outputs 0 immediately, memory unchanged, next request accepted normally after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states, lane constants.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0]  LANE_0    = 2'd0;
    localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        WSETUP = 2'd2,
        WR     = 2'd3
    } state_t;

    // Size 2'b11 is handled as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane extract with sign/zero extension, plus lane mask and bit shift for the store merge.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sgn,
    output logic [31:0] data,
    output logic [31:0] lane_mask,
    output logic [4:0]  lane_sh
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    always_comb begin
        // Halfwords only honour offset[1]; words always start at lane 0.
        lane = LANE_0;
        if (size == SZ_BYTE) begin
            lane = offset;
        end else if (size == SZ_HALF) begin
            lane = {offset[1], 1'b0};
        end
        lane_sh   = {lane, 3'b000};
        shifted   = word >> lane_sh;
        data      = shifted;
        lane_mask = MASK_WORD;
        if (size == SZ_BYTE) begin
            data      = {{24{sgn & shifted[7]}}, shifted[7:0]};
            lane_mask = MASK_BYTE << lane_sh;
        end else if (size == SZ_HALF) begin
            data      = {{16{sgn & shifted[15]}}, shifted[15:0]};
            lane_mask = MASK_HALF << lane_sh;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: byte/half/word accesses onto a word-wide memory port, sub-word stores by RMW.
// Latency: load 2, word store 3, sub-word store 4 cycles to resp_valid; misaligned reject 1 cycle.
// Backpressure: stall held high in every busy state; MEM_ACCESS_ALIGN_CHECK_EN enables misalign rejection.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_n;
    logic              r_write, r_signed;
    logic [1:0]        r_size, r_off;
    logic [DATA_W-1:0] r_wdata;
    logic              cap, req_mis;
    logic              resp_valid_n, misalign_n, mem_read_n, mem_write_n;
    logic [DATA_W-1:0] resp_rdata_n, mem_wdata_n, ld_data, lane_mask, merged;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [4:0]        lane_sh;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign req_mis = ((req_size == SZ_HALF) && req_addr[0]) ||
                     (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
    assign req_mis = 1'b0;
`endif

    mem_load_align u_align (
        .word      (mem_rdata),
        .size      (r_size),
        .offset    (r_off),
        .sgn       (r_signed),
        .data      (ld_data),
        .lane_mask (lane_mask),
        .lane_sh   (lane_sh)
    );

    assign merged = (mem_rdata & ~lane_mask) | ((r_wdata << lane_sh) & lane_mask);

    always_comb begin
        state_n      = state;
        cap          = 1'b0;
        resp_valid_n = 1'b0;
        resp_rdata_n = '0;
        misalign_n   = 1'b0;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_mis) begin
                        resp_valid_n = 1'b1;
                        misalign_n   = 1'b1;
                    end else begin
                        cap        = 1'b1;
                        mem_addr_n = {req_addr[ADDR_W-1:2], 2'b00};
                        if (req_write && is_word(req_size)) begin
                            state_n     = WSETUP;
                            mem_wdata_n = req_wdata;
                        end else begin
                            state_n    = RD;
                            mem_read_n = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                if (r_write) begin
                    state_n     = WSETUP;
                    mem_wdata_n = merged;
                end else begin
                    state_n      = IDLE;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = ld_data;
                end
            end
            WSETUP: begin
                state_n     = WR;
                mem_write_n = 1'b1;
            end
            WR: begin
                state_n      = IDLE;
                resp_valid_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // All port-facing controls come straight from flops so the memory sees no decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stall      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            misalign   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            r_write    <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= SZ_BYTE;
            r_off      <= 2'b00;
            r_wdata    <= '0;
        end else begin
            state      <= state_n;
            stall      <= (state_n != IDLE);
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            misalign   <= misalign_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_read   <= mem_read_n;
            mem_write  <= mem_write_n;
            if (cap) begin
                r_write  <= req_write;
                r_signed <= req_signed;
                r_size   <= req_size;
                r_off    <= req_addr[1:0];
                r_wdata  <= req_wdata;
            end
        end
    end

endmodule
